// File: rtl/jtframe_cen_pkg.sv
// jtframe_cen_pkg: shared types, defaults and ratio helper
// for the fractional clock-enable generator.
package jtframe_cen_pkg;

    localparam int CEN_WC = 10;

    // Master clocks the ratio helper knows about
    typedef enum logic [1:0] {
        MCLK_96,
        MCLK_48,
        MCLK_24
    } mclk_e;

    // Accumulator decision for one cycle
    typedef enum logic [1:0] {
        ACC_HOLD,
        ACC_STEP,
        ACC_WRAP,
        ACC_RECOVER
    } acc_op_e;

    typedef struct packed {
        logic [15:0] n;
        logic [15:0] m;
    } cen_ratio_t;

    function automatic int unsigned mclk_khz(input mclk_e mclk);
        int unsigned f;
        unique case (mclk)
            MCLK_96: f = 96000;
            MCLK_48: f = 48000;
            default: f = 24000;
        endcase
        return f;
    endfunction

    // Ratio that places cen[0] at tgt_khz. cen[0] runs at
    // f*n/(2m), hence the factor of two on the numerator.
    // Common factors are stripped so the operands stay small.
    function automatic cen_ratio_t cen_ratio(
        input mclk_e       mclk,
        input int unsigned tgt_khz
    );
        int unsigned a;
        int unsigned b;
        int unsigned p;
        cen_ratio_t  r;
        a = 2 * tgt_khz;
        b = mclk_khz(mclk);
        for (int j = 0; j < 3; j++) begin
            p = (j == 0) ? 2 : (j == 1) ? 3 : 5;
            for (int k = 0; k < 16; k++) begin
                if ((a % p == 0) && (b % p == 0)) begin
                    a = a / p;
                    b = b / p;
                end
            end
        end
        r.n = a[15:0];
        r.m = b[15:0];
        return r;
    endfunction

endpackage

// File: rtl/jtframe_frac_acc.sv
// jtframe_frac_acc: N/M phase accumulator emitting a base pulse.
// Ports: clk, rst_n (sync, low), en, n, m in; base out (comb).
module jtframe_frac_acc
    import jtframe_cen_pkg::*;
#(
    parameter int WC = CEN_WC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [WC-1:0] n,
    input  logic [WC-1:0] m,
    output logic          base
);

    logic [WC-1:0] acc;
    logic [WC-1:0] acc_nx;
    logic [WC:0]   sum;
    logic          idle;
    logic          recover;
    logic          wrap;
    logic          step;
    acc_op_e       op;

    assign sum = {1'b0, acc} + {1'b0, n};

    // Mutually exclusive decision terms. acc >= m also
    // covers m == 0 and a shrunken m: pulse and restart at
    // zero so the accumulator can never wrap.
    assign idle    = !en || (n == '0);
    assign recover = !idle && (acc >= m);
    assign wrap    = !idle && !recover && (sum >= {1'b0, m});
    assign step    = !idle && !recover && !wrap;

    always_comb begin
        op = ACC_HOLD;
        unique case (1'b1)
            idle:    op = ACC_HOLD;
            recover: op = ACC_RECOVER;
            wrap:    op = ACC_WRAP;
            step:    op = ACC_STEP;
            default: op = ACC_HOLD;
        endcase
    end

    always_comb begin
        acc_nx = acc;
        base   = 1'b0;
        unique case (op)
            ACC_HOLD: begin
                acc_nx = acc;
            end
            ACC_STEP: begin
                acc_nx = sum[WC-1:0];
            end
            ACC_WRAP: begin
                // acc < m here, so sum - m < n fits in WC bits
                acc_nx = sum[WC-1:0] - m;
                base   = 1'b1;
            end
            ACC_RECOVER: begin
                acc_nx = '0;
                base   = 1'b1;
            end
            default: begin
                acc_nx = acc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_nx;
        end
    end

endmodule

// File: rtl/jtframe_frac_cen_gen.sv
// jtframe_frac_cen_gen: fractional cen generator, W channels.
// Ports: clk, rst_n (sync, low), cen_en, n, m in; cen, cenb out.
module jtframe_frac_cen_gen
    import jtframe_cen_pkg::*;
#(
    parameter int W  = 2,
    parameter int WC = CEN_WC
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen_en,
    input  logic [WC-1:0] n,
    input  logic [WC-1:0] m,
    output logic [W-1:0]  cen,
    output logic [W-1:0]  cenb
);

    logic         base;
    logic [W-1:0] ec;
    logic [W-1:0] mask;
    logic [W-1:0] cen_nx;
    logic [W-1:0] cenb_nx;

    jtframe_frac_acc #(
        .WC (WC)
    ) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cen_en),
        .n     (n),
        .m     (m),
        .base  (base)
    );

    // Channel i looks at the low i+1 bits of the edge count:
    // all zero gives cen[i], only bit i set gives cenb[i].
    always_comb begin
        cen_nx  = '0;
        cenb_nx = '0;
        mask    = '0;
        for (int i = 0; i < W; i++) begin
            mask = '0;
            for (int j = 0; j <= i; j++) begin
                mask[j] = 1'b1;
            end
            cen_nx[i]  = base && ((ec & mask) == '0);
            cenb_nx[i] = base && ((ec & mask) == (W'(1) << i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ec   <= '0;
            cen  <= '0;
            cenb <= '0;
        end else begin
            cen  <= cen_nx;
            cenb <= cenb_nx;
            if (base) begin
                ec <= ec + W'(1);
            end
        end
    end

endmodule
